mul_fu_ctrl: RTL and testbench
==============================

MUL_FU_CTRL -- requirements
Module: mul_fu_ctrl

Interface
REQ-001 Parameter TAG_W, default 4, SHALL set the width of reservation-station result tags.
REQ-002 Parameter LAT, default 3, legal range 2..8, SHALL set the cycles from grant to cdb_req.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be synchronous and active-high.
REQ-005 Ports rs0_req / rs1_req, input, 1, SHALL be requester operation-valid lines.
REQ-006 Ports rs0_tag / rs1_tag, input, TAG_W, SHALL be destination tags, held with req until granted.
REQ-007 Ports rs0_a, rs0_b, rs1_a, rs1_b, input, 32, SHALL be operands, held with req until granted.
REQ-008 Ports rs0_gnt / rs1_gnt, output, 1, SHALL be combinational one-hot-or-zero grants.
REQ-009 Ports mul_a / mul_b, output, 32, SHALL drive the shared combinational 32x32 Wallace multiplier.
REQ-010 Port mul_p, input, 64, SHALL be the unsigned product mul_a*mul_b, valid in the same cycle.
REQ-011 Port flush, input, 1, SHALL discard all in-flight operations.
REQ-012 Ports cdb_req (output, 1), cdb_tag (output, TAG_W), cdb_data (output, 64) SHALL present the result to the common data bus.
REQ-013 Port cdb_gnt, input, 1, SHALL acknowledge cdb_req; transfer occurs on a cycle with cdb_req and cdb_gnt both high.
REQ-014 Port busy, output, 1, SHALL be high when any pipeline stage holds a valid operation.

Function
REQ-015 Pipeline SHALL have LAT stages, each with valid, tag and data: stage 1 holds operands, stage 2 captures mul_p, stages 3..LAT shift the product; stage LAT drives cdb_req/cdb_tag/cdb_data.
REQ-016 stall SHALL equal cdb_req AND NOT cdb_gnt; while stall is high all stages hold and no grant is issued.
REQ-017 When not stalled, all stages SHALL advance one position per cycle; bubbles (valid=0) advance like operations.
REQ-018 Grant SHALL be issued only when reset=0, flush=0, stall=0, and the requester's req=1.
REQ-019 Arbitration SHALL be round-robin: a priority pointer selects the favoured requester; after a grant the pointer moves to the other requester; with no grant it is unchanged.
REQ-020 With only one requester active, it SHALL be granted every non-stalled cycle (back-to-back throughput of 1/cycle).
REQ-021 The granted requester's tag and operands SHALL load stage 1 at the edge ending the grant cycle; without a grant stage 1 loads valid=0.
REQ-022 An operation granted in cycle t SHALL assert cdb_req in cycle t+LAT when no stall occurs; each stall cycle adds exactly one cycle.
REQ-023 mul_a/mul_b SHALL equal stage 1 operands; stage 1 operands SHALL keep their values when stage 1 is invalid (no toggling required to zero).
REQ-024 cdb_data SHALL equal the full 64-bit unsigned product; cdb_tag SHALL equal the granted tag.
REQ-025 flush SHALL clear every stage valid bit at the next edge, override stall, and suppress grants in the flush cycle; the round-robin pointer is unchanged.
REQ-026 Simultaneous flush and cdb_gnt: the transfer in that cycle SHALL count as completed; the stage is still cleared.
REQ-027 Data and tag fields of invalid stages SHALL be don't-care except at reset.

Reset
REQ-028 On reset all valid bits, cdb_req, busy, rs0_gnt, rs1_gnt SHALL be 0; cdb_tag, cdb_data, mul_a, mul_b SHALL be 0; pointer SHALL favour rs0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations with no cdb_req on the following cycle; reset overrides flush and stall.

Verification
REQ-030 Single op: rs0_req, tag=5, a=0xFFFFFFFF, b=0xFFFFFFFF, cdb_gnt tied 1 -> rs0_gnt same cycle; cdb_req exactly 3 cycles later with tag 5, data 0xFFFFFFFE00000001, busy low thereafter.
REQ-031 Contention: rs0 and rs1 both requesting continuously for 4 cycles after reset -> grants rs0,rs1,rs0,rs1; results emerge in that order back-to-back.
REQ-032 CDB backpressure: cdb_gnt low for 2 cycles while cdb_req high with 3 ops in flight -> outputs stable, no grants, no op lost or duplicated; all 3 delivered in order after cdb_gnt returns.
REQ-033 Flush: issue tags 1,2 then assert flush one cycle -> no cdb_req for tags 1,2; new op tag 3 granted next cycle appears after LAT cycles.
REQ-034 Reset mid-pipe: reset high with 2 ops in flight -> next cycle cdb_req=0, busy=0, all outputs 0, pointer favours rs0.
REQ-035 Random: 10k random operand/req/cdb_gnt/flush stimuli checked against a reference queue model of tags and 64-bit products.

Source files
------------

// File: rtl/mul_fu_ctrl.sv
// Multiplier functional-unit controller.
// Arbitrates two reservation-station requesters round-robin onto a shared
// combinational 32x32 multiplier. It carries each operation through a
// LAT-stage pipeline (stage 1 operands, stage 2 product, then shift stages)
// and presents the finished product on the common data bus with backpressure.
module mul_fu_ctrl #(
   parameter int TAG_W = 4,
   parameter int LAT   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rs0_req,
   input  logic [TAG_W-1:0] rs0_tag,
   input  logic [31:0]      rs0_a,
   input  logic [31:0]      rs0_b,
   input  logic             rs1_req,
   input  logic [TAG_W-1:0] rs1_tag,
   input  logic [31:0]      rs1_a,
   input  logic [31:0]      rs1_b,
   output logic             rs0_gnt,
   output logic             rs1_gnt,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   input  logic [63:0]      mul_p,
   input  logic             flush,
   output logic             cdb_req,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [63:0]      cdb_data,
   input  logic             cdb_gnt,
   output logic             busy
);

   // Per-stage state; index k is pipeline stage k (stage LAT faces the CDB).
   logic             r_vld  [1:LAT];
   logic [TAG_W-1:0] r_tag  [1:LAT];
   logic [63:0]      r_prod [2:LAT];
   logic [31:0]      r_a_p1;
   logic [31:0]      r_b_p1;
   // Round-robin pointer: 0 favours rs0, 1 favours rs1.
   logic             r_ptr;

   logic w_stall;
   logic w_issue_ok;
   logic w_gnt0;
   logic w_gnt1;
   logic w_busy;

   // Stall, issue permission and round-robin grant selection.
   always_comb begin
      w_stall    = r_vld[LAT] & ~cdb_gnt;
      w_issue_ok = ~reset & ~flush & ~w_stall;
      w_gnt0     = w_issue_ok & rs0_req & (~rs1_req | ~r_ptr);
      w_gnt1     = w_issue_ok & rs1_req & (~rs0_req |  r_ptr);
   end

   // Busy whenever any stage carries a valid operation.
   always_comb begin
      w_busy = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         w_busy = w_busy | r_vld[k];
      end
   end

   assign rs0_gnt  = w_gnt0;
   assign rs1_gnt  = w_gnt1;
   assign mul_a    = r_a_p1;
   assign mul_b    = r_b_p1;
   assign cdb_req  = r_vld[LAT];
   assign cdb_tag  = r_tag[LAT];
   assign cdb_data = r_prod[LAT];
   assign busy     = w_busy;

   // Pipeline advance, flush/reset clearing and pointer update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr  <= 1'b0;
         r_a_p1 <= '0;
         r_b_p1 <= '0;
         for (int k = 1; k <= LAT; k++) begin
            r_vld[k] <= 1'b0;
            r_tag[k] <= '0;
         end
         for (int k = 2; k <= LAT; k++) begin
            r_prod[k] <= '0;
         end
      end else begin
         // Grants are already suppressed under flush/stall, so the pointer
         // only moves when an operation is actually accepted.
         if (w_gnt0) begin
            r_ptr <= 1'b1;
         end else if (w_gnt1) begin
            r_ptr <= 1'b0;
         end

         if (flush) begin
            // A transfer accepted this cycle is complete; everything else is dropped.
            for (int k = 1; k <= LAT; k++) begin
               r_vld[k] <= 1'b0;
            end
         end else if (!w_stall) begin
            // Stage 1: operands of the granted requester (held when idle).
            r_vld[1] <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
               r_tag[1] <= rs0_tag;
               r_a_p1   <= rs0_a;
               r_b_p1   <= rs0_b;
            end else if (w_gnt1) begin
               r_tag[1] <= rs1_tag;
               r_a_p1   <= rs1_a;
               r_b_p1   <= rs1_b;
            end

            // Stage 2: capture the multiplier product of stage 1 operands.
            r_vld[2]  <= r_vld[1];
            r_tag[2]  <= r_tag[1];
            r_prod[2] <= mul_p;

            // Stages 3..LAT: shift the product toward the CDB.
            for (int k = 3; k <= LAT; k++) begin
               r_vld[k]  <= r_vld[k-1];
               r_tag[k]  <= r_tag[k-1];
               r_prod[k] <= r_prod[k-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_fu_ctrl.sv
// Self-checking bench for mul_fu_ctrl: directed scenarios plus a long random
// run, all compared against an operation-queue reference model.
module tb_mul_fu_ctrl;
   localparam int TAG_W = 4;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             rs0_req, rs1_req;
   logic [TAG_W-1:0] rs0_tag, rs1_tag;
   logic [31:0]      rs0_a, rs0_b, rs1_a, rs1_b;
   logic             rs0_gnt, rs1_gnt;
   logic [31:0]      mul_a, mul_b;
   logic [63:0]      mul_p;
   logic             flush;
   logic             cdb_req;
   logic [TAG_W-1:0] cdb_tag;
   logic [63:0]      cdb_data;
   logic             cdb_gnt;
   logic             busy;

   always #5 clk = ~clk;

   mul_fu_ctrl #(.TAG_W(TAG_W), .LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .rs0_req(rs0_req), .rs0_tag(rs0_tag), .rs0_a(rs0_a), .rs0_b(rs0_b),
      .rs1_req(rs1_req), .rs1_tag(rs1_tag), .rs1_a(rs1_a), .rs1_b(rs1_b),
      .rs0_gnt(rs0_gnt), .rs1_gnt(rs1_gnt),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .flush(flush),
      .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_gnt(cdb_gnt), .busy(busy)
   );

   // Behavioural stand-in for the shared Wallace multiplier.
   assign mul_p = {32'h0, mul_a} * {32'h0, mul_b};

   // Reference model: in-order list of accepted operations, each with the
   // number of non-stalled cycles since grant.
   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [63:0]      prod;
      int               age;
   } op_t;

   op_t q[$];
   bit  ptr;
   bit  e0, e1, exp_req;
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom % 4)
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Settle combinational outputs, predict grants and compare.
   task automatic settle();
      bit stall, ok;
      #1;
      exp_req = (q.size() != 0) && (q[0].age == LAT);
      stall   = exp_req && !cdb_gnt;
      ok      = !reset && !flush && !stall;
      if (ok && rs0_req && rs1_req) begin
         e0 = !ptr;
         e1 = ptr;
      end else begin
         e0 = ok && rs0_req;
         e1 = ok && rs1_req;
      end
      chk("rs0_gnt", 64'(rs0_gnt), 64'(e0));
      chk("rs1_gnt", 64'(rs1_gnt), 64'(e1));
      chk("cdb_req", 64'(cdb_req), 64'(exp_req));
      chk("busy",    64'(busy),    64'(q.size() != 0));
      if (exp_req) begin
         chk("cdb_tag",  64'(cdb_tag), 64'(q[0].tag));
         chk("cdb_data", cdb_data,     q[0].prod);
      end
   endtask

   // Apply the clock edge to the model, then move to the next drive point.
   task automatic advance();
      bit stall;
      stall = exp_req && !cdb_gnt;
      if (reset) begin
         q.delete();
         ptr = 1'b0;
      end else if (flush) begin
         q.delete();
      end else if (!stall) begin
         if (exp_req) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (e0) begin
            q.push_back(op_t'{rs0_tag, 64'(rs0_a) * 64'(rs0_b), 1});
            ptr = 1'b1;
         end
         if (e1) begin
            q.push_back(op_t'{rs1_tag, 64'(rs1_a) * 64'(rs1_b), 1});
            ptr = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   initial begin
      logic [TAG_W-1:0] exp_tags[$];
      bit g0, g1;

      reset = 1'b1; flush = 1'b0; cdb_gnt = 1'b1;
      rs0_req = 1'b0; rs0_tag = '0; rs0_a = '0; rs0_b = '0;
      rs1_req = 1'b0; rs1_tag = '0; rs1_a = '0; rs1_b = '0;
      @(negedge clk);
      cyc();
      cyc();

      // Reset state
      reset = 1'b0;
      settle();
      chk("rst_mul_a",    64'(mul_a),   64'h0);
      chk("rst_mul_b",    64'(mul_b),   64'h0);
      chk("rst_cdb_tag",  64'(cdb_tag), 64'h0);
      chk("rst_cdb_data", cdb_data,     64'h0);
      advance();

      // Single operation, all-ones operands
      rs0_req = 1'b1; rs0_tag = 4'd5; rs0_a = 32'hFFFF_FFFF; rs0_b = 32'hFFFF_FFFF;
      settle();
      chk("single_gnt", 64'(rs0_gnt), 64'h1);
      advance();
      rs0_req = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         settle();
         chk("single_early", 64'(cdb_req), 64'h0);
         advance();
      end
      settle();
      chk("single_req",  64'(cdb_req), 64'h1);
      chk("single_tag",  64'(cdb_tag), 64'h5);
      chk("single_data", cdb_data,     64'hFFFF_FFFE_0000_0001);
      advance();
      settle();
      chk("single_idle", 64'(busy), 64'h0);
      advance();

      // Contention right after reset: rs0, rs1, rs0, rs1
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      rs0_req = 1'b1; rs0_tag = 4'd1; rs0_a = $urandom; rs0_b = $urandom;
      rs1_req = 1'b1; rs1_tag = 4'd2; rs1_a = $urandom; rs1_b = $urandom;
      exp_tags = '{4'd1, 4'd2, 4'd3, 4'd4};
      for (int i = 0; i < 10; i++) begin
         settle();
         if (i < 4) begin
            chk("rr_gnt0", 64'(rs0_gnt), 64'(i % 2 == 0));
            chk("rr_gnt1", 64'(rs1_gnt), 64'(i % 2 == 1));
         end
         if (cdb_req && exp_tags.size() != 0) begin
            chk("rr_order", 64'(cdb_tag), 64'(exp_tags.pop_front()));
         end
         advance();
         if (i == 0) begin rs0_tag = 4'd3; rs0_a = $urandom; rs0_b = $urandom; end
         if (i == 1) begin rs1_tag = 4'd4; rs1_a = $urandom; rs1_b = $urandom; end
         if (i == 3) begin rs0_req = 1'b0; rs1_req = 1'b0; end
      end
      chk("rr_all_out", 64'(exp_tags.size()), 64'h0);

      // CDB backpressure with three operations in flight
      for (int i = 0; i < 3; i++) begin
         rs0_req = 1'b1; rs0_tag = 4'd7 + 4'(i); rs0_a = $urandom; rs0_b = $urandom;
         cyc();
      end
      rs0_req = 1'b0;
      cdb_gnt = 1'b0;
      rs1_req = 1'b1; rs1_tag = 4'd10; rs1_a = $urandom; rs1_b = $urandom;
      for (int j = 0; j < 2; j++) begin
         settle();
         chk("bp_req",   64'(cdb_req), 64'h1);
         chk("bp_tag",   64'(cdb_tag), 64'h7);
         chk("bp_nognt", 64'(rs1_gnt), 64'h0);
         advance();
      end
      cdb_gnt = 1'b1;
      exp_tags = '{4'd7, 4'd8, 4'd9, 4'd10};
      for (int j = 0; j < 8; j++) begin
         settle();
         if (cdb_req && exp_tags.size() != 0) begin
            chk("bp_order", 64'(cdb_tag), 64'(exp_tags.pop_front()));
         end
         g1 = e1;
         advance();
         if (g1) rs1_req = 1'b0;
      end
      chk("bp_all_out", 64'(exp_tags.size()), 64'h0);

      // Flush discards tags 1 and 2; tag 3 issues after the flush cycle
      rs0_req = 1'b1; rs0_tag = 4'd1; rs0_a = $urandom; rs0_b = $urandom;
      cyc();
      rs0_tag = 4'd2; rs0_a = $urandom; rs0_b = $urandom;
      cyc();
      rs0_tag = 4'd3; rs0_a = $urandom; rs0_b = $urandom;
      flush = 1'b1;
      settle();
      chk("fl_nognt", 64'(rs0_gnt), 64'h0);
      advance();
      flush = 1'b0;
      settle();
      chk("fl_gnt", 64'(rs0_gnt), 64'h1);
      chk("fl_gone", 64'(cdb_req), 64'h0);
      advance();
      rs0_req = 1'b0;
      for (int j = 1; j < LAT; j++) begin
         settle();
         chk("fl_gone", 64'(cdb_req), 64'h0);
         advance();
      end
      settle();
      chk("fl_new_req", 64'(cdb_req), 64'h1);
      chk("fl_new_tag", 64'(cdb_tag), 64'h3);
      advance();

      // Reset with two operations in flight (pointer left favouring rs1)
      rs0_req = 1'b1; rs0_tag = 4'd11; rs0_a = 32'h1234_5678; rs0_b = 32'h9ABC_DEF0;
      cyc();
      rs0_tag = 4'd12; rs0_a = 32'hDEAD_BEEF; rs0_b = 32'h0000_0003;
      cyc();
      rs0_req = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      rs0_req = 1'b1; rs0_tag = 4'd13; rs0_a = $urandom; rs0_b = $urandom;
      rs1_req = 1'b1; rs1_tag = 4'd14; rs1_a = $urandom; rs1_b = $urandom;
      settle();
      chk("mr_req",   64'(cdb_req),  64'h0);
      chk("mr_busy",  64'(busy),     64'h0);
      chk("mr_tag",   64'(cdb_tag),  64'h0);
      chk("mr_data",  cdb_data,      64'h0);
      chk("mr_mul_a", 64'(mul_a),    64'h0);
      chk("mr_mul_b", 64'(mul_b),    64'h0);
      chk("mr_ptr0",  64'(rs0_gnt),  64'h1);
      chk("mr_ptr1",  64'(rs1_gnt),  64'h0);
      g0 = e0; g1 = e1;
      advance();

      // Random traffic
      for (int n = 0; n < 10000; n++) begin
         if (!rs0_req || g0) begin
            rs0_req = ($urandom % 3) != 0;
            rs0_tag = TAG_W'($urandom);
            rs0_a = rnd_op(); rs0_b = rnd_op();
         end
         if (!rs1_req || g1) begin
            rs1_req = ($urandom % 3) != 0;
            rs1_tag = TAG_W'($urandom);
            rs1_a = rnd_op(); rs1_b = rnd_op();
         end
         cdb_gnt = ($urandom % 4) != 0;
         flush   = ($urandom % 50) == 0;
         reset   = ($urandom % 500) == 0;
         settle();
         g0 = e0; g1 = e1;
         advance();
      end

      // Drain
      reset = 1'b0; flush = 1'b0; cdb_gnt = 1'b1;
      rs0_req = 1'b0; rs1_req = 1'b0;
      repeat (LAT + 4) cyc();
      settle();
      chk("drain_busy", 64'(busy), 64'h0);
      advance();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
